// File: rtl/rem_issue_seq.sv
// Issue stage for the combinational signed-remainder unit: operand FIFO,
// settle-timed drive/capture sequencer, registered result port, dz counter.
module rem_issue_seq #(
    parameter int DEPTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] in_a,
    input  logic [2:0] in_b,
    output logic [2:0] rem_a,
    output logic [2:0] rem_b,
    input  logic [4:0] rem_r,
    input  logic       rem_dzf,
    input  logic       rem_sf,
    input  logic       rem_zf,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [2:0] out_a,
    output logic [2:0] out_b,
    output logic [4:0] out_r,
    output logic       out_dzf,
    output logic       out_sf,
    output logic       out_zf,
    output logic [7:0] dz_count,
    output logic       busy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        HOLD
    } state_t;

    state_t         state;
    state_t         state_nx;
    logic [2:0]     mem_a [DEPTH];
    logic [2:0]     mem_b [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [PW:0]    count;
    logic [CW-1:0]  settle_cnt;
    logic           push;
    logic           pop;
    logic           capture;
    logic           out_done;

    // Fullness ignores a same-cycle pop on purpose.
    assign in_ready = (count != (PW+1)'(DEPTH)) && !rst;
    assign push     = in_valid && in_ready;
    assign busy     = (state != IDLE);

    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        capture  = 1'b0;
        out_done = 1'b0;
        unique case (state)
            IDLE: begin
                if (count != '0) begin
                    pop      = 1'b1;
                    state_nx = DRIVE;
                end
            end
            DRIVE: begin
                if (settle_cnt == '0) begin
                    capture  = 1'b1;
                    state_nx = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    out_done = 1'b1;
                    if (count != '0) begin
                        pop      = 1'b1;
                        state_nx = DRIVE;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr] <= in_a;
            mem_b[wr_ptr] <= in_b;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_a      <= '0;
            rem_b      <= '0;
            settle_cnt <= '0;
        end else if (pop) begin
            rem_a      <= mem_a[rd_ptr];
            rem_b      <= mem_b[rd_ptr];
            settle_cnt <= CW'(SETTLE - 1);
        end else if (state == DRIVE && settle_cnt != '0) begin
            settle_cnt <= settle_cnt - 1'b1;
        end
    end

    // A divide-by-zero result is normalised: only the flag survives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_a     <= '0;
            out_b     <= '0;
            out_r     <= '0;
            out_dzf   <= 1'b0;
            out_sf    <= 1'b0;
            out_zf    <= 1'b0;
            dz_count  <= '0;
        end else if (capture) begin
            out_valid <= 1'b1;
            out_a     <= rem_a;
            out_b     <= rem_b;
            out_dzf   <= rem_dzf;
            if (rem_dzf) begin
                out_r  <= '0;
                out_sf <= 1'b0;
                out_zf <= 1'b0;
                if (dz_count != 8'hFF) dz_count <= dz_count + 1'b1;
            end else begin
                out_r  <= rem_r;
                out_sf <= rem_sf;
                out_zf <= rem_zf;
            end
        end else if (out_done) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rem_issue_seq.sv
// Self-checking bench for rem_issue_seq: SETTLE=1 and SETTLE=3 instances,
// each fed by a behavioural remainder unit and checked against a scoreboard.
module tb_rem_issue_seq;

    typedef struct packed {
        logic [4:0] r;
        logic       dzf;
        logic       sf;
        logic       zf;
    } res_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nchk = 0;
    int nerr = 0;

    logic       rst1, in_valid1, in_ready1, out_valid1, out_ready1, busy1;
    logic [2:0] in_a1, in_b1, rem_a1, rem_b1, out_a1, out_b1;
    logic [4:0] rem_r1, out_r1;
    logic       rem_dzf1, rem_sf1, rem_zf1, out_dzf1, out_sf1, out_zf1;
    logic [7:0] dz_count1;

    logic       rst3, in_valid3, in_ready3, out_valid3, out_ready3, busy3;
    logic [2:0] in_a3, in_b3, rem_a3, rem_b3, out_a3, out_b3;
    logic [4:0] rem_r3, out_r3;
    logic       rem_dzf3, rem_sf3, rem_zf3, out_dzf3, out_sf3, out_zf3;
    logic [7:0] dz_count3;

    // Expected result of a signed truncating remainder (dz normalised).
    function automatic res_t model(input logic [2:0] a, input logic [2:0] b);
        res_t m;
        int   sa;
        int   sb;
        int   q;
        if (b == 3'd0) begin
            m = '{r: 5'd0, dzf: 1'b1, sf: 1'b0, zf: 1'b0};
        end else begin
            sa = $signed(a);
            sb = $signed(b);
            q  = sa % sb;
            m  = '{r: 5'(q), dzf: 1'b0, sf: (q < 0), zf: (q == 0)};
        end
        return m;
    endfunction

    // Stand-in rem unit: on divide-by-zero its data outputs are junk.
    function automatic res_t rem_unit(input logic [2:0] a, input logic [2:0] b);
        if (b == 3'd0) return '{r: 5'b10110, dzf: 1'b1, sf: 1'b1, zf: 1'b1};
        return model(a, b);
    endfunction

    res_t ru1, ru3;
    always_comb ru1 = rem_unit(rem_a1, rem_b1);
    always_comb ru3 = rem_unit(rem_a3, rem_b3);
    assign {rem_r1, rem_dzf1, rem_sf1, rem_zf1} = ru1;
    assign {rem_r3, rem_dzf3, rem_sf3, rem_zf3} = ru3;

    rem_issue_seq #(.DEPTH(4), .SETTLE(1)) dut1 (
        .clk(clk), .rst(rst1), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_a(in_a1), .in_b(in_b1), .rem_a(rem_a1), .rem_b(rem_b1),
        .rem_r(rem_r1), .rem_dzf(rem_dzf1), .rem_sf(rem_sf1), .rem_zf(rem_zf1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_a(out_a1),
        .out_b(out_b1), .out_r(out_r1), .out_dzf(out_dzf1), .out_sf(out_sf1),
        .out_zf(out_zf1), .dz_count(dz_count1), .busy(busy1)
    );

    rem_issue_seq #(.DEPTH(4), .SETTLE(3)) dut3 (
        .clk(clk), .rst(rst3), .in_valid(in_valid3), .in_ready(in_ready3),
        .in_a(in_a3), .in_b(in_b3), .rem_a(rem_a3), .rem_b(rem_b3),
        .rem_r(rem_r3), .rem_dzf(rem_dzf3), .rem_sf(rem_sf3), .rem_zf(rem_zf3),
        .out_valid(out_valid3), .out_ready(out_ready3), .out_a(out_a3),
        .out_b(out_b3), .out_r(out_r3), .out_dzf(out_dzf3), .out_sf(out_sf3),
        .out_zf(out_zf3), .dz_count(dz_count3), .busy(busy3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard state per instance (0: SETTLE=1, 1: SETTLE=3).
    logic [5:0]  sq   [2][1024];
    int          head [2];
    int          tail [2];
    int          dzn  [2];
    int          nh   [2];
    int          hts  [2][1024];
    logic        pv   [2];
    logic        phs  [2];
    logic [13:0] pod  [2];

    task automatic mon(input int k, input logic r, input logic iv, input logic ir,
                       input logic [2:0] ia, input logic [2:0] ib,
                       input logic ov, input logic ordy,
                       input logic [13:0] od, input logic [7:0] dzc);
        res_t       e;
        logic [5:0] ent;
        logic       hs;
        int         edz;
        if (r) begin
            head[k] = 0;
            tail[k] = 0;
            dzn[k]  = 0;
            pv[k]   = 1'b0;
            phs[k]  = 1'b0;
        end else begin
            if (pv[k] && !phs[k]) begin
                chk("valid_held", 32'(ov), 32'd1);
                chk("data_stable", 32'(od), 32'(pod[k]));
            end
            if (iv && ir) begin
                sq[k][tail[k]] = {ia, ib};
                tail[k]++;
            end
            hs = ov && ordy;
            if (hs) begin
                if (head[k] == tail[k]) begin
                    chk("unexpected_result", 32'd0, 32'd1);
                end else begin
                    ent = sq[k][head[k]];
                    head[k]++;
                    e = model(ent[5:3], ent[2:0]);
                    if (e.dzf) dzn[k]++;
                    edz = (dzn[k] > 255) ? 255 : dzn[k];
                    chk("out_a", 32'(od[13:11]), 32'(ent[5:3]));
                    chk("out_b", 32'(od[10:8]), 32'(ent[2:0]));
                    chk("out_r", 32'(od[7:3]), 32'(e.r));
                    chk("out_dzf", 32'(od[2]), 32'(e.dzf));
                    chk("out_sf", 32'(od[1]), 32'(e.sf));
                    chk("out_zf", 32'(od[0]), 32'(e.zf));
                    chk("dz_count", 32'(dzc), 32'(edz));
                    hts[k][nh[k]] = cyc;
                    nh[k]++;
                end
            end
            pv[k]  = ov;
            phs[k] = hs;
            pod[k] = od;
        end
    endtask

    always @(negedge clk) begin
        mon(0, rst1, in_valid1, in_ready1, in_a1, in_b1, out_valid1, out_ready1,
            {out_a1, out_b1, out_r1, out_dzf1, out_sf1, out_zf1}, dz_count1);
        mon(1, rst3, in_valid3, in_ready3, in_a3, in_b3, out_valid3, out_ready3,
            {out_a3, out_b3, out_r3, out_dzf3, out_sf3, out_zf3}, dz_count3);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one pair to dut1 and return just after the accepting edge.
    task automatic send1(input logic [2:0] a, input logic [2:0] b, input bit rnd);
        bit done;
        done = 1'b0;
        in_valid1 = 1'b1;
        in_a1 = a;
        in_b1 = b;
        for (int i = 0; i < 200 && !done; i++) begin
            if (rnd) out_ready1 = 1'($urandom_range(0, 1));
            done = in_ready1;
            tick();
        end
        if (!done) chk("send1_timeout", 32'd0, 32'd1);
        in_valid1 = 1'b0;
    endtask

    task automatic drain(input int k);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            if (head[k] == tail[k] && ((k == 0) ? !out_valid1 : !out_valid3))
                done = 1'b1;
            else
                tick();
        end
        if (!done) chk("drain_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int acc;
        int base;
        bit take;

        rst1 = 1'b1; rst3 = 1'b1;
        in_valid1 = 1'b0; in_a1 = '0; in_b1 = '0; out_ready1 = 1'b1;
        in_valid3 = 1'b0; in_a3 = '0; in_b3 = '0; out_ready3 = 1'b1;
        tick();
        chk("rst_out_valid", 32'(out_valid1), 32'd0);
        chk("rst_busy", 32'(busy1), 32'd0);
        chk("rst_in_ready", 32'(in_ready1), 32'd0);
        chk("rst_dz_count", 32'(dz_count1), 32'd0);
        chk("rst_rem_ab", 32'({rem_a1, rem_b1}), 32'd0);
        chk("rst_out_data", 32'({out_a1, out_b1, out_r1, out_dzf1, out_sf1, out_zf1}), 32'd0);
        tick();
        rst1 = 1'b0; rst3 = 1'b0;
        tick();
        chk("idle_in_ready", 32'(in_ready1), 32'd1);

        // Latency from the accepting edge E.
        send1(3'b011, 3'b010, 1'b0);
        chk("lat_e0_busy", 32'(busy1), 32'd0);
        chk("lat_e0_valid", 32'(out_valid1), 32'd0);
        tick();
        chk("lat_e1_rem_ab", 32'({rem_a1, rem_b1}), 32'({3'b011, 3'b010}));
        chk("lat_e1_busy", 32'(busy1), 32'd1);
        chk("lat_e1_valid", 32'(out_valid1), 32'd0);
        tick();
        chk("lat_e2_valid", 32'(out_valid1), 32'd1);
        chk("lat_e2_r", 32'(out_r1), 32'd1);
        drain(0);

        send1(3'b101, 3'b010, 1'b0);
        drain(0);
        send1(3'b010, 3'b010, 1'b0);
        drain(0);
        send1(3'b011, 3'b000, 1'b0);
        drain(0);
        chk("dz_first", 32'(dz_count1), 32'd1);

        for (int i = 0; i < 260; i++) send1(3'($urandom), 3'b000, 1'b0);
        drain(0);
        chk("dz_saturate", 32'(dz_count1), 32'd255);

        for (int i = 0; i < 40; i++) send1(3'($urandom), 3'($urandom), 1'b1);
        out_ready1 = 1'b1;
        drain(0);

        // Back-pressure: FIFO plus one in flight.
        out_ready1 = 1'b0;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            in_valid1 = 1'b1;
            in_a1 = 3'(i + 1);
            in_b1 = 3'(i);
            if (in_ready1) acc++;
            tick();
        end
        in_valid1 = 1'b0;
        chk("bp_accepted", 32'(acc), 32'd5);
        chk("bp_in_ready", 32'(in_ready1), 32'd0);
        repeat (6) tick();
        chk("bp_valid", 32'(out_valid1), 32'd1);
        chk("bp_first_a", 32'(out_a1), 32'd1);
        base = nh[0];
        out_ready1 = 1'b1;
        drain(0);
        chk("bp_results", 32'(nh[0] - base), 32'd5);
        for (int i = base + 1; i < nh[0]; i++)
            chk("bp_spacing", 32'(hts[0][i] - hts[0][i-1]), 32'd2);

        // SETTLE=3 streaming.
        base = nh[1];
        out_ready3 = 1'b1;
        in_valid3 = 1'b1;
        in_a3 = 3'b001;
        in_b3 = 3'b000;
        for (int i = 0; i < 60; i++) begin
            take = in_ready3;
            tick();
            if (take) begin
                in_a3 = 3'($urandom);
                in_b3 = 3'($urandom);
            end
        end
        in_valid3 = 1'b0;
        drain(1);
        chk("s3_enough", 32'(nh[1] - base >= 14), 32'd1);
        for (int i = base + 1; i < nh[1]; i++)
            chk("s3_spacing", 32'(hts[1][i] - hts[1][i-1]), 32'd4);
        chk("s3_dz_before", 32'(dz_count3 != 8'd0), 32'd1);

        // Reset during DRIVE with three entries queued.
        out_ready3 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid3 = 1'b1;
            in_a3 = 3'(i + 1);
            in_b3 = 3'b000;
            tick();
        end
        in_valid3 = 1'b0;
        chk("pre_rst_busy", 32'(busy3), 32'd1);
        chk("pre_rst_valid", 32'(out_valid3), 32'd0);
        rst3 = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(out_valid3), 32'd0);
        chk("mid_rst_busy", 32'(busy3), 32'd0);
        chk("mid_rst_dz", 32'(dz_count3), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready3), 32'd0);
        tick();
        rst3 = 1'b0;
        out_ready3 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("post_rst_quiet", 32'({out_valid3, busy3}), 32'd0);
        end
        base = nh[1];
        in_valid3 = 1'b1;
        in_a3 = 3'b010;
        in_b3 = 3'b011;
        take = 1'b0;
        for (int i = 0; i < 20 && !take; i++) begin
            take = in_ready3;
            tick();
        end
        in_valid3 = 1'b0;
        drain(1);
        chk("post_rst_result", 32'(nh[1] - base), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
